fir_interp2: RTL

Interpolate-by-2 polyphase FIR on AXI-Stream; it is the transmit-side counterpart of the 15-tap receive low-pass FIR. For each accepted input sample it emits two output samples. The output equals zero-stuffing the input by 2 and filtering with the same 15 symmetric taps: −2, −3, −4, 0, 9, 21, 32, 36, 32, 21, 9, 0, −4, −3, −2. It sits between the baseband sample source and the RFSoC DAC path. It sustains one input per two clocks.

---
 rtl/fir_interp2_pkg.sv | 30 +++
 rtl/fir_interp2_if.sv | 29 ++
 rtl/fir_interp2_polyphase_dot.sv | 31 +++
 rtl/fir_interp2.sv | 116 +++++++++++
 4 files changed

// File: rtl/fir_interp2_pkg.sv
// fir_interp2 shared definitions.
// Tap sets, phase split and FSM states for the interpolate-by-2 FIR.
package fir_interp_pkg;

    localparam int NUM_COEFFS = 15;
    localparam int NUM_EVEN   = 8;
    localparam int NUM_ODD    = 7;
    localparam int COEF_W     = 8;

    typedef logic signed [COEF_W-1:0] coef_t;

    // h0, h2, ... h14 : phase 0 (aligned with the real input sample)
    localparam coef_t EVEN_COEFFS [NUM_EVEN] = '{
        -8'sd2, -8'sd4, 8'sd9, 8'sd32,
        8'sd32, 8'sd9, -8'sd4, -8'sd2
    };

    // h1, h3, ... h13 : phase 1 (aligned with the stuffed zero)
    localparam coef_t ODD_COEFFS [NUM_ODD] = '{
        -8'sd3, 8'sd0, 8'sd21, 8'sd36,
        8'sd21, 8'sd0, -8'sd3
    };

    typedef enum logic [1:0] {
        EMPTY,
        OUT0,
        OUT1
    } state_t;

endpackage

// File: rtl/fir_interp2_if.sv
// AXI-Stream bundle for fir_interp2.
// master drives tvalid/tdata/tlast/tstrb, slave drives tready.
interface fir_interp2_if #(
    parameter int W = 32
) ();

    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic           tlast;
    logic [W/8-1:0] tstrb;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tstrb,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tstrb,
        output tready
    );

endinterface

// File: rtl/fir_interp2_polyphase_dot.sv
// polyphase_dot: combinational signed dot product, wrapped to W bits.
// Ports: x[N] signed samples in, y = low W bits of sum(x[i]*COEFFS[i]).
module polyphase_dot
    import fir_interp_pkg::*;
#(
    parameter int    N = 8,
    parameter int    W = 32,
    parameter coef_t COEFFS [N] = '{default: coef_t'(0)}
) (
    input  logic signed [W-1:0] x [N],
    output logic        [W-1:0] y
);

    // Low W bits of a two's complement sum of products depend only on
    // the low W bits of every operand, so a W-bit accumulator yields
    // exactly the truncated full-precision result.
    logic signed [W-1:0] acc;
    logic signed [W-1:0] ce;

    always_comb begin
        acc = '0;
        ce  = '0;
        for (int i = 0; i < N; i++) begin
            ce  = {{(W-COEF_W){COEFFS[i][COEF_W-1]}}, COEFFS[i]};
            acc = acc + x[i] * ce;
        end
    end

    assign y = acc;

endmodule

// File: rtl/fir_interp2.sv
// fir_interp2: interpolate-by-2 polyphase 15-tap FIR on AXI-Stream.
// Ports: s00_axis_aclk, s00_axis_areset (async, high), s00_axis (slave
// in), m00_axis (master out). Two outputs (y0, y1) per accepted input.
module fir_interp2
    import fir_interp_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input logic           s00_axis_aclk,
    input logic           s00_axis_areset,
    fir_interp2_if.slave  s00_axis,
    fir_interp2_if.master m00_axis
);

    localparam int WI = C_S00_AXIS_TDATA_WIDTH;
    localparam int WO = C_M00_AXIS_TDATA_WIDTH;
    localparam int SW = WI / 8;

    state_t state_q;
    state_t state_d;

    logic signed [WI-1:0] dl_q  [NUM_EVEN];
    logic signed [WI-1:0] dl_d  [NUM_EVEN];
    logic signed [WI-1:0] odd_x [NUM_ODD];

    logic [WI-1:0] y0_d;
    logic [WI-1:0] y1_d;
    logic [WO-1:0] y0_q;
    logic [WO-1:0] y1_q;
    logic          last_q;
    logic [SW-1:0] strb_q;
    logic          in_hs;

    // Delay line as it will look after shifting in the offered sample;
    // both phase sums are taken from this view.
    always_comb begin
        dl_d[0] = $signed(s00_axis.tdata);
        for (int i = 1; i < NUM_EVEN; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        for (int i = 0; i < NUM_ODD; i++) begin
            odd_x[i] = dl_d[i];
        end
    end

    polyphase_dot #(
        .N      (NUM_EVEN),
        .W      (WI),
        .COEFFS (EVEN_COEFFS)
    ) u_even (
        .x (dl_d),
        .y (y0_d)
    );

    polyphase_dot #(
        .N      (NUM_ODD),
        .W      (WI),
        .COEFFS (ODD_COEFFS)
    ) u_odd (
        .x (odd_x),
        .y (y1_d)
    );

    // Accept in EMPTY, or in OUT1 when y1 leaves this cycle so a new
    // sample can follow back-to-back.
    assign s00_axis.tready = (state_q == EMPTY) |
                             ((state_q == OUT1) & m00_axis.tready);
    assign in_hs = s00_axis.tvalid & s00_axis.tready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (s00_axis.tvalid) state_d = OUT0;
            end
            OUT0: begin
                if (m00_axis.tready) state_d = OUT1;
            end
            OUT1: begin
                if (m00_axis.tready) begin
                    state_d = s00_axis.tvalid ? OUT0 : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q <= EMPTY;
            dl_q    <= '{default: '0};
            y0_q    <= '0;
            y1_q    <= '0;
            last_q  <= 1'b0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                dl_q   <= dl_d;
                y0_q   <= y0_d;
                y1_q   <= y1_d;
                last_q <= s00_axis.tlast;
                strb_q <= s00_axis.tstrb;
            end
        end
    end

    // Outputs are muxed from registers only, so they stay stable
    // while stalled.
    assign m00_axis.tvalid = (state_q != EMPTY);
    assign m00_axis.tdata  = (state_q == OUT1) ? y1_q : y0_q;
    assign m00_axis.tlast  = (state_q == OUT1) & last_q;
    assign m00_axis.tstrb  = strb_q;

endmodule
